// File: rtl/host_uart_bridge_if.sv
// host_uart_bridge_if: serial lines, command-processor FIFO handshakes and sticky error flags.
interface host_uart_bridge_if;
  logic       i_uart_rx;
  logic       o_uart_tx;
  logic       o_data_valid;
  logic [7:0] o_data;
  logic       i_input_full;
  logic       o_data_read;
  logic [7:0] i_data;
  logic       i_output_empty;
  logic       o_rx_frame_err;
  logic       o_rx_overrun;
  logic       i_err_clear;
  modport master (
    input  i_uart_rx, i_input_full, i_data, i_output_empty, i_err_clear,
    output o_uart_tx, o_data_valid, o_data, o_data_read, o_rx_frame_err, o_rx_overrun
  );
  modport slave (
    output i_uart_rx, i_input_full, i_data, i_output_empty, i_err_clear,
    input  o_uart_tx, o_data_valid, o_data, o_data_read, o_rx_frame_err, o_rx_overrun
  );
endinterface

// File: rtl/host_uart_bridge.sv
// host_uart_bridge: 8N1 UART bridging a byte stream to command-processor input/output FIFOs.
module host_uart_bridge #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  host_uart_bridge_if.master bus
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST      = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF      = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] STOP_LAST = W'(CLKS_PER_BIT - 2);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  rx_state_t  rx_state, rx_next;
  tx_state_t  tx_state, tx_next;
  logic [1:0] sync;
  logic       rx_s, rx_prev, rx_tick, rx_done, rx_good, push, hold_full;
  logic       frame_err, overrun;
  logic [W-1:0] rx_cnt, rx_cnt_n, tx_cnt, tx_cnt_n;
  logic [2:0] rx_idx, tx_idx;
  logic [7:0] rx_shift, hold_data, tx_shift;
  logic       tx_tick, pop, tx_line;
  assign rx_s = sync[1];
  always_comb begin
    rx_next = rx_state;
    rx_tick = rx_cnt == (rx_state == RX_START ? HALF : LAST);
    case (rx_state)
      RX_IDLE:  rx_next = (rx_prev && !rx_s) ? RX_START : RX_IDLE;
      RX_START: rx_next = rx_tick ? (rx_s ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  rx_next = (rx_tick && rx_idx == 3'd7) ? RX_STOP : RX_DATA;
      default:  rx_next = rx_tick ? RX_IDLE : RX_STOP;
    endcase
    rx_cnt_n = (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
    rx_done  = rx_state == RX_STOP && rx_tick;
    rx_good  = rx_done && rx_s;
    push     = hold_full && !bus.i_input_full;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync      <= '1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync     <= {sync[0], bus.i_uart_rx};
      rx_prev  <= rx_s;
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_n;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
      hold_full <= rx_good || (hold_full && !push);
      if (rx_good && (!hold_full || push)) hold_data <= rx_shift;
      frame_err <= (rx_done && !rx_s) || (frame_err && !bus.i_err_clear);
      overrun   <= (rx_good && hold_full && !push) || (overrun && !bus.i_err_clear);
    end
  end
  // stop state ends one cycle early so the first idle cycle completes the stop bit
  always_comb begin
    tx_next = tx_state;
    pop     = tx_state == TX_IDLE && !bus.i_output_empty && !i_rst;
    tx_tick = tx_cnt == (tx_state == TX_STOP ? STOP_LAST : LAST);
    case (tx_state)
      TX_IDLE:  tx_next = pop ? TX_START : TX_IDLE;
      TX_START: tx_next = tx_tick ? TX_DATA : TX_START;
      TX_DATA:  tx_next = (tx_tick && tx_idx == 3'd7) ? TX_STOP : TX_DATA;
      default:  tx_next = tx_tick ? TX_IDLE : TX_STOP;
    endcase
    tx_cnt_n = (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
    tx_line  = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] : 1'b1;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_n;
      if (pop) tx_shift <= bus.i_data;
      else if (tx_state == TX_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_idx   <= tx_idx + 3'd1;
      end
    end
  end
  assign bus.o_uart_tx      = tx_line;
  assign bus.o_data_read    = pop;
  assign bus.o_data_valid   = push;
  assign bus.o_data         = hold_data;
  assign bus.o_rx_frame_err = frame_err;
  assign bus.o_rx_overrun   = overrun;
endmodule

// File: tb/tb_host_uart_bridge.sv
// tb_host_uart_bridge: scoreboard model of frames, holding register and flags plus pinned directed vectors.
module tb_host_uart_bridge;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  host_uart_bridge_if bus();
  host_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.master));
  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic       txq[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic       exp_bit;
  logic [7:0] rd_byte;
  logic [19:0] pat = 20'b10111111001100000010;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (bus.o_data_read && !rst && out_q.size() > 0) out_q.delete(0);
    bus.i_output_empty <= (out_q.size() == 0);
    bus.i_data <= (out_q.size() > 0) ? out_q[0] : 8'h00;
  end
  always @(negedge clk) begin
    if (rst) begin
      txq.delete();
      exp_q.delete();
      m_ferr = 1'b0;
      m_ovr = 1'b0;
    end else begin
      exp_bit = (txq.size() > 0) ? txq.pop_front() : 1'b1;
      chk("tx_line", bus.o_uart_tx, exp_bit);
      chk("pop_strobe", bus.o_data_read, (txq.size() == 0) && !bus.i_output_empty);
      if (bus.o_data_read) begin
        pops++;
        rd_byte = bus.i_data;
        for (int k = 0; k < 10; k++)
          for (int c = 0; c < CPB; c++)
            txq.push_back(k == 0 ? 1'b0 : k == 9 ? 1'b1 : rd_byte[k-1]);
      end
      chk("push_valid", bus.o_data_valid, (exp_q.size() > 0) && !bus.i_input_full);
      if (bus.o_data_valid && exp_q.size() > 0) begin
        rd_byte = exp_q.pop_front();
        chk("push_data", bus.o_data, rd_byte);
      end
      chk("frame_err", bus.o_rx_frame_err, m_ferr);
      chk("overrun", bus.o_rx_overrun, m_ovr);
    end
  end
  task automatic send_frame(logic [7:0] b, logic stop);
    for (int i = 0; i < 10; i++) begin
      bus.i_uart_rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (CPB) @(negedge clk);
    end
    bus.i_uart_rx = 1'b1;
  endtask
  task automatic frame_done(logic [7:0] b, logic stop);
    @(posedge clk);
    if (!stop) m_ferr = 1'b1;
    else if (exp_q.size() > 0) m_ovr = 1'b1;
    else exp_q.push_back(b);
    @(negedge clk);
  endtask
  task automatic clear_flags();
    @(posedge clk);
    #1 bus.i_err_clear = 1'b1;
    @(posedge clk);
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    #1 bus.i_err_clear = 1'b0;
    @(negedge clk);
  endtask
  task automatic set_full(logic v);
    @(posedge clk);
    #1 bus.i_input_full = v;
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_uart_rx = 1'b1;
    bus.i_input_full = 1'b0;
    bus.i_err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.o_uart_tx, 1);
    chk("rst_valid", bus.o_data_valid, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_read", bus.o_data_read, 0);
    chk("rst_ferr", bus.o_rx_frame_err, 0);
    chk("rst_ovr", bus.o_rx_overrun, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'hA5, 1'b1);
    chk("a5_early", bus.o_data_valid, 0);
    frame_done(8'hA5, 1'b1);
    chk("a5_valid", bus.o_data_valid, 1);
    chk("a5_data", bus.o_data, 8'hA5);
    @(negedge clk);
    chk("a5_single", bus.o_data_valid, 0);
    chk("a5_flags", {bus.o_rx_frame_err, bus.o_rx_overrun}, 0);
    set_full(1'b1);
    send_frame(8'h3C, 1'b1);
    frame_done(8'h3C, 1'b1);
    repeat (100) @(negedge clk);
    chk("3c_held", bus.o_data, 8'h3C);
    chk("3c_no_push", bus.o_data_valid, 0);
    @(posedge clk);
    #1 bus.i_input_full = 1'b0;
    @(negedge clk);
    chk("3c_valid", bus.o_data_valid, 1);
    chk("3c_data", bus.o_data, 8'h3C);
    @(negedge clk);
    chk("3c_single", bus.o_data_valid, 0);
    set_full(1'b1);
    send_frame(8'h11, 1'b1);
    frame_done(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    frame_done(8'h22, 1'b1);
    chk("ovr_set", bus.o_rx_overrun, 1);
    chk("ovr_ferr", bus.o_rx_frame_err, 0);
    chk("ovr_kept", bus.o_data, 8'h11);
    @(posedge clk);
    #1 bus.i_input_full = 1'b0;
    @(negedge clk);
    chk("ovr_valid", bus.o_data_valid, 1);
    chk("ovr_data", bus.o_data, 8'h11);
    repeat (10) @(negedge clk);
    chk("ovr_sticky", bus.o_rx_overrun, 1);
    clear_flags();
    chk("ovr_clear", bus.o_rx_overrun, 0);
    send_frame(8'h55, 1'b0);
    frame_done(8'h55, 1'b0);
    chk("ferr_set", bus.o_rx_frame_err, 1);
    chk("ferr_no_push", bus.o_data_valid, 0);
    clear_flags();
    chk("ferr_clear", bus.o_rx_frame_err, 0);
    bus.i_uart_rx = 1'b0;
    @(negedge clk);
    bus.i_uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_flags", {bus.o_rx_frame_err, bus.o_rx_overrun}, 0);
    chk("glitch_no_push", bus.o_data_valid, 0);
    out_q.push_back(8'h81);
    out_q.push_back(8'h7E);
    for (int i = 0; i < 20 && !bus.o_data_read; i++) @(negedge clk);
    chk("tx_pop_seen", bus.o_data_read, 1);
    fork
      begin
        send_frame(8'hC6, 1'b1);
        frame_done(8'hC6, 1'b1);
      end
    join_none
    for (int j = 0; j < 20; j++) begin
      repeat (2) @(negedge clk);
      chk("tx_wave", bus.o_uart_tx, pat[j]);
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("tx_pops", pops, 2);
    chk("c6_pushed", exp_q.size(), 0);
    send_frame(8'h99, 1'b0);
    frame_done(8'h99, 1'b0);
    chk("pre_rst_ferr", bus.o_rx_frame_err, 1);
    out_q.push_back(8'hC3);
    bus.i_uart_rx = 1'b0;
    repeat (12) @(negedge clk);
    bus.i_uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_tx_low", bus.o_uart_tx, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", bus.o_uart_tx, 1);
    chk("mid_rst_valid", bus.o_data_valid, 0);
    chk("mid_rst_data", bus.o_data, 0);
    chk("mid_rst_read", bus.o_data_read, 0);
    chk("mid_rst_flags", {bus.o_rx_frame_err, bus.o_rx_overrun}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_push", bus.o_data_valid, 0);
    send_frame(8'h96, 1'b1);
    frame_done(8'h96, 1'b1);
    chk("post_rst_valid", bus.o_data_valid, 1);
    chk("post_rst_data", bus.o_data, 8'h96);
    repeat (5) @(negedge clk);
    chk("end_pops", pops, 3);
    chk("end_exp_q", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
